// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, controller states and error codes for the RPN sequencer
package calc_pkg;

  localparam logic [4:0] KEY_OP_BASE = 5'h10;
  localparam logic [4:0] KEY_ENTER   = 5'h18;
  localparam logic [4:0] KEY_DROP    = 5'h19;
  localparam logic [4:0] KEY_CLEAR   = 5'h1A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    ERROR = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2
  } err_t;

endpackage

// File: rtl/rpn_stack.sv
// rtl/rpn_stack.sv - DEPTH x WIDTH operand stack with push, dup, pop1, pop2 and clear
module rpn_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop1,
  input  logic             i_pop2,
  input  logic             i_dup,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_next,
  output logic [DW-1:0]    o_depth,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DW-1:0]    r_depth;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_next_idx;
  logic             w_full;
  logic             w_empty;

  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_wr_idx   = AW'(r_depth);
  assign w_top_idx  = AW'(r_depth - DW'(1));
  assign w_next_idx = AW'(r_depth - DW'(2));

  // Contents below r_depth are never reset; only the occupancy is.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_depth <= '0;
    end else if (i_push && !w_full) begin
      r_mem[w_wr_idx] <= i_push_data;
      r_depth         <= r_depth + DW'(1);
    end else if (i_dup && !w_full && !w_empty) begin
      r_mem[w_wr_idx] <= r_mem[w_top_idx];
      r_depth         <= r_depth + DW'(1);
    end else if (i_pop2 && (r_depth >= DW'(2))) begin
      r_depth <= r_depth - DW'(2);
    end else if (i_pop1 && !w_empty) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign o_top   = r_mem[w_top_idx];
  assign o_next  = r_mem[w_next_idx];
  assign o_depth = r_depth;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/alu_rpn_sequencer.sv
// rtl/alu_rpn_sequencer.sv - keypad-driven RPN controller sequencing the shared ALU
module alu_rpn_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int NUM_OPS = 5,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] display,
  output logic [DW-1:0]    depth,
  output logic             busy,
  output logic             error,
  output logic [1:0]       err_code,
  output logic             ovf_flag
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = $clog2(NDIG + 1);

  state_t           r_state, w_state_nxt;
  err_t             r_err;
  logic [WIDTH-1:0] r_entry;
  logic [CW-1:0]    r_count;
  logic             r_entry_active;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;
  logic [2:0]       r_alu_op;
  logic             r_ovf;

  logic [WIDTH-1:0] w_top, w_next, w_push_data;
  logic [DW-1:0]    w_depth;
  logic             w_full, w_empty;
  logic             w_push, w_pop1, w_pop2, w_dup, w_clr;
  logic             w_entry_shift, w_entry_clr, w_load_alu, w_set_err, w_ovf_load;
  err_t             w_err_val;
  logic             w_key_clear, w_is_digit, w_is_op, w_op_ok, w_need_ok;

  assign w_key_clear = key_valid && (key_code == KEY_CLEAR);
  assign w_is_digit  = (key_code[4] == 1'b0);
  assign w_is_op     = (key_code[4:3] == KEY_OP_BASE[4:3]);
  assign w_op_ok     = (int'(key_code[2:0]) < NUM_OPS);
  assign w_need_ok   = r_entry_active ? !w_empty : (w_depth >= DW'(2));

  rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop1      (w_pop1),
    .i_pop2      (w_pop2),
    .i_dup       (w_dup),
    .i_clear     (w_clr),
    .o_top       (w_top),
    .o_next      (w_next),
    .o_depth     (w_depth),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_push        = 1'b0;
    w_push_data   = r_entry;
    w_pop1        = 1'b0;
    w_pop2        = 1'b0;
    w_dup         = 1'b0;
    w_clr         = 1'b0;
    w_entry_shift = 1'b0;
    w_entry_clr   = 1'b0;
    w_load_alu    = 1'b0;
    w_set_err     = 1'b0;
    w_err_val     = ERR_NONE;
    w_ovf_load    = 1'b0;
    if (w_key_clear) begin
      w_clr       = 1'b1;
      w_entry_clr = 1'b1;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            if (w_is_digit) begin
              w_entry_shift = (r_count < CW'(NDIG));
            end else if (key_code == KEY_ENTER) begin
              if (r_entry_active || !w_empty) begin
                if (w_full) begin
                  w_set_err = 1'b1;
                  w_err_val = ERR_OVF;
                end else if (r_entry_active) begin
                  w_push      = 1'b1;
                  w_entry_clr = 1'b1;
                end else begin
                  w_dup = 1'b1;
                end
              end
            end else if (key_code == KEY_DROP) begin
              if (r_entry_active) begin
                w_entry_clr = 1'b1;
              end else if (!w_empty) begin
                w_pop1 = 1'b1;
              end else begin
                w_set_err = 1'b1;
                w_err_val = ERR_UNF;
              end
            end else if (w_is_op && w_op_ok) begin
              if (!w_need_ok) begin
                w_set_err = 1'b1;
                w_err_val = ERR_UNF;
              end else begin
                // Operands leave the stack now; the result returns next cycle.
                w_load_alu  = 1'b1;
                w_pop1      = r_entry_active;
                w_pop2      = !r_entry_active;
                w_entry_clr = 1'b1;
                w_state_nxt = EXEC;
              end
            end
            if (w_set_err) w_state_nxt = ERROR;
          end
        end
        EXEC: begin
          w_push      = 1'b1;
          w_push_data = alu_result;
          w_ovf_load  = 1'b1;
          w_state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry        <= '0;
      r_count        <= '0;
      r_entry_active <= 1'b0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_op       <= '0;
      r_err          <= ERR_NONE;
      r_ovf          <= 1'b0;
    end else begin
      if (w_entry_clr) begin
        r_entry        <= '0;
        r_count        <= '0;
        r_entry_active <= 1'b0;
      end else if (w_entry_shift) begin
        r_entry        <= {r_entry[WIDTH-5:0], key_code[3:0]};
        r_count        <= r_count + CW'(1);
        r_entry_active <= 1'b1;
      end
      if (w_load_alu) begin
        r_alu_b  <= r_entry_active ? r_entry : w_top;
        r_alu_a  <= r_entry_active ? w_top : w_next;
        r_alu_op <= key_code[2:0];
      end
      if (w_key_clear) begin
        r_err <= ERR_NONE;
        r_ovf <= 1'b0;
      end else begin
        if (w_set_err)  r_err <= w_err_val;
        if (w_ovf_load) r_ovf <= alu_overflow;
      end
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign display  = r_entry_active ? r_entry : (w_empty ? '0 : w_top);
  assign depth    = w_depth;
  assign busy     = (r_state == EXEC);
  assign error    = (r_state == ERROR);
  assign err_code = r_err;
  assign ovf_flag = r_ovf;

endmodule

// File: tb/tb_alu_rpn_sequencer.sv
// tb/tb_alu_rpn_sequencer.sv - directed self-checking bench for alu_rpn_sequencer
module tb_alu_rpn_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [15:0] alu_a, alu_b, alu_result, display;
  logic [2:0]  alu_op;
  logic        alu_overflow;
  logic [2:0]  depth;
  logic        busy, error, ovf_flag;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  alu_rpn_sequencer #(.WIDTH(16), .DEPTH(4), .NUM_OPS(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .display      (display),
    .depth        (depth),
    .busy         (busy),
    .error        (error),
    .err_code     (err_code),
    .ovf_flag     (ovf_flag)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU: add, sub, and, or, xor; carry/borrow as overflow.
  always_comb begin
    alu_result   = 16'h0000;
    alu_overflow = 1'b0;
    case (alu_op)
      3'd0: {alu_overflow, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_overflow, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      default: ;
    endcase
  end

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 5'h1F;
  endtask

  task automatic test_reset;
    rst = 1'b1; key_valid = 1'b0; key_code = 5'h1F;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (display !== 16'h0000) begin bad++; $display("FAIL reset_display got=%h want=%h", display, 16'h0000); end
    total++; if (depth !== 3'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth); end
    total++; if ({busy, error, err_code, ovf_flag} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {busy, error, err_code, ovf_flag}); end
    total++; if ({alu_a, alu_b, alu_op} !== 35'd0) begin bad++; $display("FAIL reset_alu got=%h/%h/%0d want=0/0/0", alu_a, alu_b, alu_op); end
  endtask

  task automatic test_basic_add;
    press(5'h01); press(5'h02); press(5'h18);
    total++; if (display !== 16'h0012) begin bad++; $display("FAIL add_enter_display got=%h want=%h", display, 16'h0012); end
    total++; if (depth !== 3'd1) begin bad++; $display("FAIL add_enter_depth got=%0d want=1", depth); end
    press(5'h03);
    total++; if (display !== 16'h0003) begin bad++; $display("FAIL add_entry_display got=%h want=%h", display, 16'h0003); end
    press(5'h10);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy got=%b want=1", busy); end
    total++; if (alu_a !== 16'h0012 || alu_b !== 16'h0003 || alu_op !== 3'd0) begin bad++; $display("FAIL add_operands got=%h/%h/%0d want=0012/0003/0", alu_a, alu_b, alu_op); end
    total++; if (depth !== 3'd0) begin bad++; $display("FAIL add_exec_depth got=%0d want=0", depth); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_one_cycle got=%b want=0", busy); end
    total++; if (display !== 16'h0015 || depth !== 3'd1) begin bad++; $display("FAIL add_result got=%h/%0d want=0015/1", display, depth); end
    press(5'h15); press(5'h1F);
    total++; if (busy !== 1'b0 || depth !== 3'd1 || display !== 16'h0015) begin bad++; $display("FAIL invalid_op_ignored got=%b/%0d/%h want=0/1/0015", busy, depth, display); end
  endtask

  task automatic test_digits_dup_drop;
    press(5'h1A);
    press(5'h01); press(5'h02); press(5'h03); press(5'h04); press(5'h05);
    total++; if (display !== 16'h1234) begin bad++; $display("FAIL digit_limit got=%h want=%h", display, 16'h1234); end
    press(5'h18); press(5'h18);
    total++; if (depth !== 3'd2 || display !== 16'h1234) begin bad++; $display("FAIL dup got=%0d/%h want=2/1234", depth, display); end
    press(5'h11);
    total++; if (alu_a !== 16'h1234 || alu_b !== 16'h1234 || alu_op !== 3'd1) begin bad++; $display("FAIL stack_operands got=%h/%h/%0d want=1234/1234/1", alu_a, alu_b, alu_op); end
    @(negedge clk);
    total++; if (depth !== 3'd1 || display !== 16'h0000) begin bad++; $display("FAIL stack_op_result got=%0d/%h want=1/0000", depth, display); end
    press(5'h19);
    total++; if (depth !== 3'd0) begin bad++; $display("FAIL drop_pop got=%0d want=0", depth); end
    press(5'h05); press(5'h19);
    total++; if (display !== 16'h0000 || depth !== 3'd0 || error !== 1'b0) begin bad++; $display("FAIL drop_entry got=%h/%0d/%b want=0000/0/0", display, depth, error); end
    press(5'h19);
    total++; if (error !== 1'b1 || err_code !== 2'd2) begin bad++; $display("FAIL drop_underflow got=%b/%0d want=1/2", error, err_code); end
  endtask

  task automatic test_stack_overflow;
    press(5'h1A);
    press(5'h07);
    for (int i = 0; i < 5; i++) press(5'h18);
    total++; if (error !== 1'b1 || err_code !== 2'd1 || depth !== 3'd4) begin bad++; $display("FAIL push_overflow got=%b/%0d/%0d want=1/1/4", error, err_code, depth); end
    press(5'h03);
    total++; if (display !== 16'h0007) begin bad++; $display("FAIL error_ignores_digit got=%h want=%h", display, 16'h0007); end
    press(5'h1A);
    total++; if (depth !== 3'd0 || error !== 1'b0 || display !== 16'h0000 || err_code !== 2'd0) begin bad++; $display("FAIL clear_from_error got=%0d/%b/%h/%0d want=0/0/0000/0", depth, error, display, err_code); end
  endtask

  task automatic test_operator_underflow;
    press(5'h09); press(5'h11);
    total++; if (error !== 1'b1 || err_code !== 2'd2 || display !== 16'h0009) begin bad++; $display("FAIL op_underflow got=%b/%0d/%h want=1/2/0009", error, err_code, display); end
    total++; if (alu_a !== 16'h1234 || alu_b !== 16'h1234 || alu_op !== 3'd1) begin bad++; $display("FAIL op_underflow_alu_hold got=%h/%h/%0d want=1234/1234/1", alu_a, alu_b, alu_op); end
    press(5'h1A);
  endtask

  task automatic test_alu_overflow;
    for (int i = 0; i < 4; i++) press(5'h0F);
    press(5'h18); press(5'h01); press(5'h10);
    @(negedge clk);
    total++; if (ovf_flag !== 1'b1 || depth !== 3'd1 || display !== 16'h0000) begin bad++; $display("FAIL alu_ovf_set got=%b/%0d/%h want=1/1/0000", ovf_flag, depth, display); end
    press(5'h02); press(5'h10);
    @(negedge clk);
    total++; if (ovf_flag !== 1'b0 || display !== 16'h0002 || depth !== 3'd1) begin bad++; $display("FAIL alu_ovf_clear got=%b/%h/%0d want=0/0002/1", ovf_flag, display, depth); end
  endtask

  task automatic test_back_to_back_abort;
    press(5'h1A);
    press(5'h04); press(5'h18); press(5'h05); press(5'h12);
    press(5'h1A);
    total++; if (depth !== 3'd0 || busy !== 1'b0 || display !== 16'h0000) begin bad++; $display("FAIL clear_in_exec got=%0d/%b/%h want=0/0/0000", depth, busy, display); end
    press(5'h04); press(5'h18); press(5'h05); press(5'h13);
    total++; if (busy !== 1'b1 || alu_a !== 16'h0004 || alu_b !== 16'h0005) begin bad++; $display("FAIL rst_exec_setup got=%b/%h/%h want=1/0004/0005", busy, alu_a, alu_b); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({alu_a, alu_b, alu_op} !== 35'd0 || display !== 16'h0000 || depth !== 3'd0) begin bad++; $display("FAIL rst_in_exec_data got=%h/%h/%0d/%h/%0d want=0", alu_a, alu_b, alu_op, display, depth); end
    total++; if ({busy, error, err_code, ovf_flag} !== 5'b0) begin bad++; $display("FAIL rst_in_exec_flags got=%b want=00000", {busy, error, err_code, ovf_flag}); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic_add;
    test_digits_dup_drop;
    test_stack_overflow;
    test_operator_underflow;
    test_alu_overflow;
    test_back_to_back_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
